// File: rtl/serial_char_rx_if.sv
// Bundle between the serial character receiver (slave) and its environment (master).
// Macro RX_PARITY_EN adds the parity_err strobe for 8E1 framing.
interface serial_char_rx_if;
  logic       rxd;
  logic [7:0] char_out;
  logic       char_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;
`ifdef RX_PARITY_EN
  logic       parity_err;
`endif

  // rxd is a raw asynchronous line; the outputs are registered strobes/levels
  // with no backpressure, so there is no valid/ready handshake on this bus.
  modport master (
    output rxd,
    input  char_out, char_valid, frame_err, busy, state_dbg
`ifdef RX_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  rxd,
    output char_out, char_valid, frame_err, busy, state_dbg
`ifdef RX_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/serial_char_rx.sv
// 8N1 LSB-first serial character receiver with a mid-bit sampling FSM.
// Define RX_PARITY_EN to receive 8E1 frames and report parity errors on parity_err.
module serial_char_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  serial_char_rx_if.slave rx_if
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
`ifdef RX_PARITY_EN
    PARITY = 3'd5,
`endif
    BREAK  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      char_q, char_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            busy_q;
  logic            rxd_s;
`ifdef RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  assign rxd_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    char_d  = char_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit that is no longer low at its midpoint is treated as a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          shreg_d[idx_q] = rxd_s;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          par_d   = rxd_s;
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (!rxd_s) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else begin
            state_d = IDLE;
`ifdef RX_PARITY_EN
            if ((^shreg_q) ^ par_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              char_d  = shreg_q;
            end
`else
            valid_d = 1'b1;
            char_d  = shreg_q;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rx_if.rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != IDLE);
`ifdef RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_if.char_out   = char_q;
  assign rx_if.char_valid = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.busy       = busy_q;
  assign rx_if.state_dbg  = state_q;
`ifdef RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_serial_char_rx.sv
// Self-checking bench for serial_char_rx: scoreboard of expected output events.
// Build with RX_PARITY_EN defined to also exercise the 8E1 parity path.
module tb_serial_char_rx;
  localparam int CPB = 4;
  // Line fall to char_valid: two synchroniser flops, the E0 edge, then HALF_BIT + 9*CPB.
  localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;
  localparam int FRAME_CYCLES = 10 * CPB;

  localparam logic [1:0] EV_CHAR = 2'd0;
  localparam logic [1:0] EV_FERR = 2'd1;
  localparam logic [1:0] EV_PERR = 2'd2;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   frame_start_cyc;
  int   valid_cycs[$];
  logic [9:0] exp_q[$];
  logic [7:0] model_char;

  serial_char_rx_if rx_if ();

  serial_char_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (rx_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] data);
    exp_q.push_back({kind, data});
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    logic par_bit;
    par_bit = (^data) ^ par_flip;
    frame_start_cyc = cyc;
    rx_if.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.rxd = data[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    rx_if.rxd = par_bit;
    repeat (CPB) @(negedge clk);
`endif
    rx_if.rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_if.rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] data);
    model_char = data;
    expect_evt(EV_CHAR, data);
    send_frame(data, 1'b1, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_char_out"}, rx_if.char_out, 8'h00);
    check({tag, "_char_valid"}, rx_if.char_valid, 1'b0);
    check({tag, "_frame_err"}, rx_if.frame_err, 1'b0);
    check({tag, "_busy"}, rx_if.busy, 1'b0);
    check({tag, "_state"}, rx_if.state_dbg, 3'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic perr;
    logic [1:0] kind;
    logic [9:0] exp_evt;
`ifdef RX_PARITY_EN
    perr = rx_if.parity_err;
`else
    perr = 1'b0;
`endif
    if (reset && (rx_if.char_valid || rx_if.frame_err || perr)) begin
      check("strobe_excl", 32'(rx_if.char_valid) + 32'(rx_if.frame_err) + 32'(perr), 1);
      kind = rx_if.char_valid ? EV_CHAR : (rx_if.frame_err ? EV_FERR : EV_PERR);
      if (rx_if.char_valid) valid_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_evt", {kind, rx_if.char_out}, 32'hFFFF_FFFF);
      end else begin
        exp_evt = exp_q.pop_front();
        check("evt", {kind, rx_if.char_out}, exp_evt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    logic [7:0] begin_str [7];
    begin_str = '{8'h20, 8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20};
    n_checks   = 0;
    n_errors   = 0;
    model_char = 8'h00;
    reset      = 1'b0;
    rx_if.rxd  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single 'b' with exact latency from the line fall.
    valid_cycs.delete();
    send_good(8'h62);
    repeat (4) @(negedge clk);
    check("b_count", valid_cycs.size(), 1);
    if (valid_cycs.size() > 0) check("b_latency", valid_cycs[0] - frame_start_cyc, LATENCY);
    check("b_held", rx_if.char_out, 8'h62);

    // Back-to-back " begin " with no idle gaps.
    valid_cycs.delete();
    for (int i = 0; i < 7; i++) send_good(begin_str[i]);
    repeat (4) @(negedge clk);
    check("begin_count", valid_cycs.size(), 7);
    for (int i = 1; i < 7; i++)
      if (i < valid_cycs.size()) check("begin_gap", valid_cycs[i] - valid_cycs[i-1], FRAME_CYCLES);

    // One-cycle glitch: START aborts at the half-bit sample.
    rx_if.rxd = 1'b0;
    @(negedge clk);
    rx_if.rxd = 1'b1;
    busy_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rx_if.busy) busy_cnt++;
    end
    check("glitch_busy_cycles", busy_cnt, 2);
    check("glitch_char_held", rx_if.char_out, 8'h20);

    // Framing error followed by a long break, then a clean 'E'.
    expect_evt(EV_FERR, model_char);
    send_frame(8'h45, 1'b0, 1'b0);
    rx_if.rxd = 1'b0;
    repeat (20) @(negedge clk);
    check("break_busy", rx_if.busy, 1'b1);
    check("break_state", rx_if.state_dbg, 3'd4);
    rx_if.rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("break_exit_busy", rx_if.busy, 1'b0);
    check("ferr_char_held", rx_if.char_out, 8'h20);
    send_good(8'h45);
    repeat (4) @(negedge clk);
    check("E_char", rx_if.char_out, 8'h45);

    // Reset pulse during data bit 3; bits 3..7 are high so the tail cannot false-start.
    fork
      send_frame(8'hFA, 1'b1, 1'b0);
      begin
        repeat (18) @(negedge clk);
        reset = 1'b0;
        #1;
        model_char = 8'h00;
        check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    check("after_reset_char", rx_if.char_out, 8'h00);
    send_good(8'h6E);
    repeat (4) @(negedge clk);
    check("n_char", rx_if.char_out, 8'h6E);

`ifdef RX_PARITY_EN
    send_good(8'h64);
    repeat (4) @(negedge clk);
    check("d_char", rx_if.char_out, 8'h64);
    expect_evt(EV_PERR, 8'h64);
    send_frame(8'h64, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("perr_char_held", rx_if.char_out, 8'h64);
`endif

    repeat (10) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
